resize_unpack: RTL and testbench
================================

RESIZE_UNPACK -- requirements
Module: resize_unpack

Interface
REQ-001 SHALL have parameter OUT_W, default 16, width of each extended output field (legal range 7..64).
REQ-002 SHALL have parameter SIGNED_MASK, default 12'h0F0, where bit k=1 means field k is declared signed.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, packed word present.
REQ-006 SHALL have port in_ready, output, 1, block accepts a packed word.
REQ-007 SHALL have port in_data, input, 128, packed word: bits [11:0] are transmitted sign bits s0..s11; field k is at bits [12+6k+5 : 12+6k] for k=0..11; bits [127:84] are ignored.
REQ-008 SHALL have port out_valid, output, 1, field result present.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port out_idx, output, 4, index k of the current field (0..11).
REQ-011 SHALL have port out_value, output, OUT_W, field k extended to OUT_W bits.
REQ-012 SHALL have port out_mismatch, output, 1, transmitted sign bit differs from expected sign bit.

Function
REQ-013 SHALL implement states IDLE and EMIT.
REQ-014 SHALL assert in_ready in IDLE, and in EMIT only when out_idx==11 and out_ready==1.
REQ-015 SHALL capture in_data into a holding register on in_valid&&in_ready, set out_idx=0, and enter EMIT; first out_valid follows in the next cycle (latency 1).
REQ-016 SHALL hold out_valid=1 throughout EMIT; out_idx, out_value and out_mismatch SHALL remain stable while out_valid&&!out_ready.
REQ-017 SHALL increment out_idx on each out_valid&&out_ready when out_idx<11.
REQ-018 SHALL, on a handshake at out_idx==11, return to IDLE, or stay in EMIT with out_idx=0 if a new word is accepted in the same cycle (back-to-back, no bubble).
REQ-019 SHALL form out_value by sign-extending field k from its bit 5 when SIGNED_MASK[k]=1, and by zero-extending it otherwise.
REQ-020 SHALL define the expected sign as field bit 5 when SIGNED_MASK[k]=1 and 0 otherwise; out_mismatch = s_k XOR expected sign.
REQ-021 SHALL ignore in_valid whenever in_ready=0; the holding register SHALL change only on an input handshake.

Reset
REQ-022 SHALL, on rst, immediately force IDLE, out_valid=0, out_idx=0, out_value=0, out_mismatch=0, clear the holding register, and abandon any partial word.
REQ-023 SHALL assert in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-024 SHALL, when RESIZE_UNPACK_ERRCNT_EN is defined, add output err_count (8 bits, reset 0) that increments on each output handshake with out_mismatch=1 and saturates at 255.
REQ-025 SHALL, when RESIZE_UNPACK_ERRCNT_EN is undefined, omit the err_count port and its counter; all other behaviour is identical.

Structure
REQ-026 SHALL place the state enum, FIELD_W=6, NUM_FIELDS=12 and SIGN_BASE=12 constants in package resize_unpack_pkg.
REQ-027 SHALL implement the per-field extend and compare logic in one sub-module, resize_unpack_ext (inputs: 6-bit field, signed flag, sign bit; outputs: value and mismatch).

Verification
REQ-028 Default params; field0=6'b011010, s0=0, out_ready=1 -> idx0 value 16'h001A, mismatch 0.
REQ-029 Field5 (signed)=6'b101000, s5=1 -> idx5 value 16'hFFE8, mismatch 0; with s5=0 instead -> mismatch 1.
REQ-030 Field1 (unsigned)=6'b101000, s1=1 -> value 16'h0028, mismatch 1; with ERRCNT_EN, err_count=1 after that handshake.
REQ-031 out_ready held low 3 cycles at idx 4 -> idx, value and mismatch stable; 12 handshakes total per word; in_ready=0 until idx 11.
REQ-032 Two words presented back-to-back with out_ready=1 -> 24 consecutive out_valid cycles, idx sequence 0..11,0..11, no bubble.
REQ-033 rst asserted at idx 6 -> out_valid=0 at once; after release in_ready=1; the next word starts at idx 0 and err_count=0.

Source files
------------

// File: rtl/resize_unpack_pkg.sv
// rtl/resize_unpack_pkg.sv - shared state encoding and packed-word layout constants for resize_unpack
package resize_unpack_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int FIELD_W    = 6;
  localparam int NUM_FIELDS = 12;
  localparam int SIGN_BASE  = 12;

  // Only the sign bits and the twelve fields are held; upper input bits are don't-care.
  localparam int HOLD_W = SIGN_BASE + FIELD_W * NUM_FIELDS;

  localparam logic [3:0] LAST_IDX = 4'(NUM_FIELDS - 1);

endpackage

// File: rtl/resize_unpack_ext.sv
// rtl/resize_unpack_ext.sv - extends one 6-bit field to OUT_W bits and flags a disagreeing transmitted sign bit
module resize_unpack_ext
  import resize_unpack_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic [FIELD_W-1:0] field,
  input  logic               is_signed,
  input  logic               sign_bit,
  output logic [OUT_W-1:0]   value,
  output logic               mismatch
);

  // The fill bit doubles as the expected sign: field msb when signed, zero otherwise.
  logic fill_bit;

  assign fill_bit = is_signed & field[FIELD_W-1];
  assign value    = {{(OUT_W - FIELD_W){fill_bit}}, field};
  assign mismatch = sign_bit ^ fill_bit;

endmodule

// File: rtl/resize_unpack.sv
// rtl/resize_unpack.sv - unpacks twelve 6-bit fields per word into OUT_W results; RESIZE_UNPACK_ERRCNT_EN adds err_count
module resize_unpack
  import resize_unpack_pkg::*;
#(
  parameter int                    OUT_W       = 16,
  parameter logic [NUM_FIELDS-1:0] SIGNED_MASK = 12'h0F0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_idx,
  output logic [OUT_W-1:0] out_value,
  output logic             out_mismatch
`ifdef RESIZE_UNPACK_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam logic [15:0] MASK16 = 16'(SIGNED_MASK);

  state_t              state;
  state_t              state_nx;
  logic [HOLD_W-1:0]   hold;
  logic [3:0]          idx;
  logic                accept;
  logic                out_hs;
  logic                last;
  logic [FIELD_W-1:0]  fields [16];
  logic                unused_hi;

  assign unused_hi = ^in_data[127:HOLD_W];

  assign last   = (idx == LAST_IDX);
  assign accept = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) state_nx = EMIT;
      end
      EMIT: begin
        if (out_hs && last) state_nx = accept ? EMIT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Accepting on the final handshake keeps the output stream bubble-free across words.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      EMIT: begin
        out_valid = 1'b1;
        in_ready  = last & out_ready;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (accept) begin
      hold <= in_data[HOLD_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 4'd0;
    end else if (accept) begin
      idx <= 4'd0;
    end else if (out_hs) begin
      idx <= last ? 4'd0 : idx + 4'd1;
    end
  end

  // Padded to 16 entries so the 4-bit index never selects outside the table.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      fields[i] = '0;
    end
    for (int k = 0; k < NUM_FIELDS; k++) begin
      fields[k] = hold[SIGN_BASE + FIELD_W * k +: FIELD_W];
    end
  end

  resize_unpack_ext #(
    .OUT_W (OUT_W)
  ) u_ext (
    .field     (fields[idx]),
    .is_signed (MASK16[idx]),
    .sign_bit  (hold[idx]),
    .value     (out_value),
    .mismatch  (out_mismatch)
  );

  assign out_idx = idx;

`ifdef RESIZE_UNPACK_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (out_hs && out_mismatch && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_resize_unpack.sv
// tb/tb_resize_unpack.sv - directed bench for resize_unpack with hand-computed field results
module tb_resize_unpack;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_idx;
  logic [15:0]  out_value;
  logic         out_mismatch;
`ifdef RESIZE_UNPACK_ERRCNT_EN
  logic [7:0]   err_count;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int hs_cnt      = 0;
  int exp_cnt     = 0;

  logic [5:0]  fa [12];
  logic [15:0] ev [12];
  logic        em [12];
  logic [127:0] word_a;
  logic [127:0] word_b;

  resize_unpack dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .out_value    (out_value),
    .out_mismatch (out_mismatch)
`ifdef RESIZE_UNPACK_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) hs_cnt = hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] build(input logic [11:0] signs, input logic [43:0] upper);
    logic [127:0] w;
    w = '0;
    w[11:0]   = signs;
    w[127:84] = upper;
    for (int k = 0; k < 12; k++) w[12 + 6 * k +: 6] = fa[k];
    return w;
  endfunction

  // Called at the negedge following acceptance; word B differs from A only in s5.
  task automatic run_word(input bit use_b, input bit have_next, input logic [127:0] next_w,
                          input int stall_at, input bit junk, input int stop_at);
    logic [15:0] v;
    logic        m;
    int          h0;
    in_valid = junk;
    if (junk) in_data = ~word_a;
    h0 = hs_cnt;
    for (int k = 0; k <= stop_at; k++) begin
      v = ev[k];
      m = em[k] | (use_b && k == 5);
      check("out_valid", out_valid, 1);
      check("out_idx", out_idx, k);
      check("out_value", out_value, v);
      check("out_mismatch", out_mismatch, m);
      check("in_ready", in_ready, (k == 11));
`ifdef RESIZE_UNPACK_ERRCNT_EN
      check("err_count", err_count, exp_cnt);
`endif
      if (k == stop_at && stop_at < 11) return;
      if (k == stall_at) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_valid", out_valid, 1);
          check("stall_idx", out_idx, k);
          check("stall_value", out_value, v);
          check("stall_mismatch", out_mismatch, m);
          check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
      if (k == 11) begin
        in_valid = have_next;
        if (have_next) in_data = next_w;
      end
      if (m && exp_cnt < 255) exp_cnt++;
      @(negedge clk);
    end
    check("handshakes", hs_cnt - h0, 12);
  endtask

  initial begin
    fa = '{6'h1A, 6'h28, 6'h3F, 6'h00, 6'h20, 6'h28, 6'h1F, 6'h3F, 6'h15, 6'h2A, 6'h01, 6'h30};
    ev = '{16'h001A, 16'h0028, 16'h003F, 16'h0000, 16'hFFE0, 16'hFFE8,
           16'h001F, 16'hFFFF, 16'h0015, 16'h002A, 16'h0001, 16'h0030};
    em = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    word_a = build(12'h43A, 44'hDEAD_BEEF_C0F);
    word_b = build(12'h41A, 44'h5A5_A5A5_A5A5);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_value", out_value, 0);
    check("rst_out_mismatch", out_mismatch, 0);
    rst = 1'b0;
    #1 check("post_rst_in_ready", in_ready, 1);

    // Word A with a stall at idx 4 and in_valid held high while not ready.
    in_valid = 1'b1;
    in_data  = word_a;
    @(negedge clk);
    run_word(1'b0, 1'b0, '0, 4, 1'b1, 11);
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);

    // Back-to-back B then A with no bubble.
    in_valid = 1'b1;
    in_data  = word_b;
    @(negedge clk);
    run_word(1'b1, 1'b1, word_a, -1, 1'b0, 11);
    run_word(1'b0, 1'b0, '0, -1, 1'b0, 11);
    check("b2b_idle_out_valid", out_valid, 0);

    // Reset in the middle of a word.
    in_valid = 1'b1;
    in_data  = word_a;
    @(negedge clk);
    run_word(1'b0, 1'b0, '0, -1, 1'b0, 6);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_idx", out_idx, 0);
    check("mid_rst_out_value", out_value, 0);
    check("mid_rst_out_mismatch", out_mismatch, 0);
    exp_cnt = 0;
`ifdef RESIZE_UNPACK_ERRCNT_EN
    check("mid_rst_err_count", err_count, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1 check("mid_rst_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = word_b;
    @(negedge clk);
    run_word(1'b1, 1'b0, '0, -1, 1'b0, 11);
    check("final_out_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
